mfp_ahb_lite_cmd_master: RTL



---
 rtl/mfp_ahb_lite_cmd_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_lite_cmd_master.sv
//============================================================================
// Module   : mfp_ahb_lite_cmd_master
// Desc     : AHB-Lite initiator. Turns a valid/ready command stream into
//            single AHB-Lite transfers with pipelined address/data phases,
//            wait-state support and two-cycle ERROR handling. Every accepted
//            command produces exactly one in-order response.
// Options  : MFP_AHB_MASTER_ALIGN_CHECK_EN - when defined, illegal-size or
//            misaligned commands are accepted but never driven on the bus;
//            they complete in order with rsp_err = 1.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mfp_ahb_lite_cmd_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  // command stream
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  // response stream
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        idle,
  // AHB-Lite initiator bus
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;

  // Address-phase slot
  logic        r_ap_valid;
  logic        r_ap_write;
  logic [31:0] r_ap_addr;
  logic [2:0]  r_ap_size;
  logic [31:0] r_ap_wdata;
  logic        r_ap_bad;

  // Data-phase slot (address/size no longer needed once on the bus)
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [31:0] r_dp_wdata;
  logic        r_dp_bad;

  // Retry slot: holds the address phase cancelled by an ERROR response
  logic        r_rt_valid;
  logic        r_rt_write;
  logic [31:0] r_rt_addr;
  logic [2:0]  r_rt_size;
  logic [31:0] r_rt_wdata;
  logic        r_rt_bad;

  // Registered response strobe
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_cmd_bad;
  logic        w_err1;
  logic        w_accept;
  logic        w_ap_drive;

`ifdef MFP_AHB_MASTER_ALIGN_CHECK_EN
  // Flag commands that must not reach the bus: illegal size or misaligned.
  always_comb begin
    w_cmd_bad = 1'b0;
    case (cmd_size)
      3'd0:    w_cmd_bad = 1'b0;
      3'd1:    w_cmd_bad = cmd_addr[0];
      3'd2:    w_cmd_bad = |cmd_addr[1:0];
      default: w_cmd_bad = 1'b1;
    endcase
  end
`else
  assign w_cmd_bad = 1'b0;
`endif

  // First ERROR cycle: a real (bus-driven) data phase reports ERROR with HREADY low.
  assign w_err1     = r_dp_valid & ~r_dp_bad & ~HREADY & HRESP;

  // A new command can enter AP only if AP is free at this edge and no retry is pending.
  assign cmd_ready  = HRESETn & ~r_rt_valid & ~w_err1 & (~r_ap_valid | HREADY);
  assign w_accept   = cmd_valid & cmd_ready;

  // Bad commands occupy AP but show as IDLE on the bus.
  assign w_ap_drive = r_ap_valid & ~r_ap_bad;

  assign HTRANS     = w_ap_drive ? c_TRANS_NONSEQ : c_TRANS_IDLE;
  assign HADDR      = w_ap_drive ? r_ap_addr  : 32'd0;
  assign HWRITE     = w_ap_drive ? r_ap_write : 1'b0;
  assign HSIZE      = w_ap_drive ? r_ap_size  : 3'd0;
  assign HWDATA     = (r_dp_valid & r_dp_write & ~r_dp_bad) ? r_dp_wdata : 32'd0;

  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_rsp_err;
  assign rsp_rdata  = r_rsp_rdata;
  assign idle       = ~r_ap_valid & ~r_dp_valid & ~r_rt_valid;

  // Pipeline advance: accept into AP, AP->DP on HREADY, AP<->RT around ERROR, retire DP.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_ap_valid  <= 1'b0;
      r_ap_write  <= 1'b0;
      r_ap_addr   <= 32'd0;
      r_ap_size   <= 3'd0;
      r_ap_wdata  <= 32'd0;
      r_ap_bad    <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_wdata  <= 32'd0;
      r_dp_bad    <= 1'b0;
      r_rt_valid  <= 1'b0;
      r_rt_write  <= 1'b0;
      r_rt_addr   <= 32'd0;
      r_rt_size   <= 3'd0;
      r_rt_wdata  <= 32'd0;
      r_rt_bad    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;

      if (w_err1) begin
        // Park the pending address phase so the bus shows IDLE in the second error cycle.
        if (r_ap_valid) begin
          r_rt_valid <= 1'b1;
          r_rt_write <= r_ap_write;
          r_rt_addr  <= r_ap_addr;
          r_rt_size  <= r_ap_size;
          r_rt_wdata <= r_ap_wdata;
          r_rt_bad   <= r_ap_bad;
          r_ap_valid <= 1'b0;
        end
      end else if (HREADY) begin
        if (r_dp_valid) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_dp_bad | HRESP;
          r_rsp_rdata <= (!r_dp_bad && !HRESP && !r_dp_write) ? HRDATA : 32'd0;
        end
        r_dp_valid <= r_ap_valid;
        r_dp_write <= r_ap_write;
        r_dp_wdata <= r_ap_wdata;
        r_dp_bad   <= r_ap_bad;
        if (r_rt_valid) begin
          r_ap_valid <= 1'b1;
          r_ap_write <= r_rt_write;
          r_ap_addr  <= r_rt_addr;
          r_ap_size  <= r_rt_size;
          r_ap_wdata <= r_rt_wdata;
          r_ap_bad   <= r_rt_bad;
          r_rt_valid <= 1'b0;
        end else if (w_accept) begin
          r_ap_valid <= 1'b1;
          r_ap_write <= cmd_write;
          r_ap_addr  <= cmd_addr;
          r_ap_size  <= cmd_size;
          r_ap_wdata <= cmd_wdata;
          r_ap_bad   <= w_cmd_bad;
        end else begin
          r_ap_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Wait state with AP empty: a new command may start its address phase.
        r_ap_valid <= 1'b1;
        r_ap_write <= cmd_write;
        r_ap_addr  <= cmd_addr;
        r_ap_size  <= cmd_size;
        r_ap_wdata <= cmd_wdata;
        r_ap_bad   <= w_cmd_bad;
      end
    end
  end

endmodule

`default_nettype wire
